alu_op_collector: RTL and testbench

Upstream issue stage for `ALU_design`. It accepts commands whose operands may arrive in separate cycles, tagged by a per-request `INP_VALID` mask. It waits a bounded time for any missing operand, then issues one complete, single-cycle `CE` pulse to the ALU. It also enforces an issue gap after multiply commands and flags requests that time out.

---
 rtl/alu_op_collector.sv | 245 ++++++++++++++++++++++++
 tb/tb_alu_op_collector.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_collector.sv
// ============================================================================
//  Module      : alu_op_collector
//  Description : Issue stage in front of ALU_design. Collects operands that
//                may arrive over several cycles, issues one CE pulse per
//                complete request, spaces issues after multiplies and drops
//                requests whose operands never arrive.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_op_collector #(
    parameter int WIDTH_O = 8,
    parameter int WIDTH_C = 4,
    parameter int TIMEOUT = 16,
    parameter int MUL_GAP = 2
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               IN_VALID,
    output logic               IN_READY,
    input  logic [WIDTH_C-1:0] IN_CMD,
    input  logic               IN_MODE,
    input  logic               IN_CIN,
    input  logic [1:0]         IN_INP_VALID,
    input  logic [WIDTH_O-1:0] IN_OPA,
    input  logic [WIDTH_O-1:0] IN_OPB,
    output logic [WIDTH_O-1:0] OPA_1,
    output logic [WIDTH_O-1:0] OPB_1,
    output logic [WIDTH_C-1:0] CMD,
    output logic               MODE,
    output logic               CIN,
    output logic [1:0]         INP_VALID,
    output logic               CE,
    output logic               TIMEOUT_ERR
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_ISSUE = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    localparam logic [7:0]         CNT_LAST = 8'(TIMEOUT - 1);
    localparam logic [3:0]         GAP_LAST = 4'(MUL_GAP - 1);
    localparam logic               HAS_GAP  = (MUL_GAP > 0);
    localparam logic [WIDTH_C-1:0] CMD_MUL0 = WIDTH_C'(9);
    localparam logic [WIDTH_C-1:0] CMD_MUL1 = WIDTH_C'(10);

    state_t             state_q, state_d;
    logic [WIDTH_C-1:0] cmd_q, cmd_d;
    logic               mode_q, mode_d;
    logic               cin_q, cin_d;
    logic [WIDTH_O-1:0] opa_q, opa_d;
    logic [WIDTH_O-1:0] opb_q, opb_d;
    logic [1:0]         have_q, have_d;
    logic [1:0]         req_q, req_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [3:0]         gap_q, gap_d;

    logic               ready_q, ready_d;
    logic               ce_q, ce_d;
    logic               terr_q, terr_d;
    logic [WIDTH_O-1:0] opa_o_q, opa_o_d;
    logic [WIDTH_O-1:0] opb_o_q, opb_o_d;
    logic [WIDTH_C-1:0] cmd_o_q, cmd_o_d;
    logic               mode_o_q, mode_o_d;
    logic               cin_o_q, cin_o_d;
    logic [1:0]         iv_o_q, iv_o_d;

    logic [1:0]         w_req;
    logic [1:0]         w_take;

    // Operands each command actually consumes; unknown codes need both.
    always_comb begin
        w_req = 2'b11;
        if (IN_MODE) begin
            if (IN_CMD == WIDTH_C'(4) || IN_CMD == WIDTH_C'(5)) begin
                w_req = 2'b01;
            end else if (IN_CMD == WIDTH_C'(6) || IN_CMD == WIDTH_C'(7)) begin
                w_req = 2'b10;
            end
        end else begin
            if (IN_CMD == WIDTH_C'(6) || IN_CMD == WIDTH_C'(8) || IN_CMD == WIDTH_C'(9)) begin
                w_req = 2'b01;
            end else if (IN_CMD == WIDTH_C'(7) || IN_CMD == WIDTH_C'(10) || IN_CMD == WIDTH_C'(11)) begin
                w_req = 2'b10;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        mode_d   = mode_q;
        cin_d    = cin_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        have_d   = have_q;
        req_d    = req_q;
        cnt_d    = cnt_q;
        gap_d    = gap_q;
        ce_d     = 1'b0;
        terr_d   = 1'b0;
        opa_o_d  = opa_o_q;
        opb_o_d  = opb_o_q;
        cmd_o_d  = cmd_o_q;
        mode_o_d = mode_o_q;
        cin_o_d  = cin_o_q;
        iv_o_d   = iv_o_q;
        w_take   = 2'b00;

        case (state_q)
            S_IDLE: begin
                if (IN_VALID && IN_INP_VALID != 2'b00) begin
                    cmd_d  = IN_CMD;
                    mode_d = IN_MODE;
                    cin_d  = IN_CIN;
                    w_take = IN_INP_VALID;
                    have_d = IN_INP_VALID;
                    req_d  = w_req;
                    if ((IN_INP_VALID & w_req) == w_req) begin
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = '0;
                    end
                end
            end
            S_WAIT: begin
                // Only still-missing operands are taken: first value wins.
                if (IN_VALID) begin
                    w_take = IN_INP_VALID & req_q & ~have_q;
                end
                have_d = have_q | w_take;
                if ((have_d & req_q) == req_q) begin
                    state_d = S_ISSUE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                    terr_d  = 1'b1;
                    have_d  = 2'b00;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_ISSUE: begin
                have_d = 2'b00;
                if (mode_q && (cmd_q == CMD_MUL0 || cmd_q == CMD_MUL1) && HAS_GAP) begin
                    state_d = S_HOLD;
                    gap_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HOLD: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (w_take[0]) begin
            opa_d = IN_OPA;
        end
        if (w_take[1]) begin
            opb_d = IN_OPB;
        end

        // Issue outputs are loaded on the edge that enters ISSUE so that CE
        // and the operand bundle appear together in the ISSUE cycle.
        if (state_d == S_ISSUE) begin
            ce_d     = 1'b1;
            opa_o_d  = req_d[0] ? opa_d : '0;
            opb_o_d  = req_d[1] ? opb_d : '0;
            cmd_o_d  = cmd_d;
            mode_o_d = mode_d;
            cin_o_d  = cin_d;
            iv_o_d   = req_d;
        end

        ready_d = (state_d == S_IDLE) || (state_d == S_WAIT);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= S_IDLE;
            cmd_q    <= '0;
            mode_q   <= 1'b0;
            cin_q    <= 1'b0;
            opa_q    <= '0;
            opb_q    <= '0;
            have_q   <= 2'b00;
            req_q    <= 2'b00;
            cnt_q    <= '0;
            gap_q    <= '0;
            ready_q  <= 1'b1;
            ce_q     <= 1'b0;
            terr_q   <= 1'b0;
            opa_o_q  <= '0;
            opb_o_q  <= '0;
            cmd_o_q  <= '0;
            mode_o_q <= 1'b0;
            cin_o_q  <= 1'b0;
            iv_o_q   <= 2'b00;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            mode_q   <= mode_d;
            cin_q    <= cin_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            have_q   <= have_d;
            req_q    <= req_d;
            cnt_q    <= cnt_d;
            gap_q    <= gap_d;
            ready_q  <= ready_d;
            ce_q     <= ce_d;
            terr_q   <= terr_d;
            opa_o_q  <= opa_o_d;
            opb_o_q  <= opb_o_d;
            cmd_o_q  <= cmd_o_d;
            mode_o_q <= mode_o_d;
            cin_o_q  <= cin_o_d;
            iv_o_q   <= iv_o_d;
        end
    end

    assign IN_READY    = ready_q;
    assign CE          = ce_q;
    assign TIMEOUT_ERR = terr_q;
    assign OPA_1       = opa_o_q;
    assign OPB_1       = opb_o_q;
    assign CMD         = cmd_o_q;
    assign MODE        = mode_o_q;
    assign CIN         = cin_o_q;
    assign INP_VALID   = iv_o_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_op_collector.sv
// ============================================================================
//  Module      : tb_alu_op_collector
//  Description : Self-checking bench for alu_op_collector (scoreboard of
//                expected issue bundles, one task per scenario).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_op_collector;

    localparam int TIMEOUT = 16;
    localparam int MUL_GAP = 2;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_cmd;
    logic       in_mode;
    logic       in_cin;
    logic [1:0] in_iv;
    logic [7:0] in_opa;
    logic [7:0] in_opb;
    logic [7:0] opa_1;
    logic [7:0] opb_1;
    logic [3:0] cmd;
    logic       mode;
    logic       cin;
    logic [1:0] inp_valid;
    logic       ce;
    logic       terr;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] cmd;
        logic       mode;
        logic       cin;
        logic [1:0] iv;
    } txn_t;

    txn_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    alu_op_collector #(
        .WIDTH_O (8),
        .WIDTH_C (4),
        .TIMEOUT (TIMEOUT),
        .MUL_GAP (MUL_GAP)
    ) dut (
        .CLK          (clk),
        .RST          (rst),
        .IN_VALID     (in_valid),
        .IN_READY     (in_ready),
        .IN_CMD       (in_cmd),
        .IN_MODE      (in_mode),
        .IN_CIN       (in_cin),
        .IN_INP_VALID (in_iv),
        .IN_OPA       (in_opa),
        .IN_OPB       (in_opb),
        .OPA_1        (opa_1),
        .OPB_1        (opb_1),
        .CMD          (cmd),
        .MODE         (mode),
        .CIN          (cin),
        .INP_VALID    (inp_valid),
        .CE           (ce),
        .TIMEOUT_ERR  (terr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic txn_t observed();
        return {opa_1, opb_1, cmd, mode, cin, inp_valid};
    endfunction

    task automatic drive(input logic v, input logic [3:0] c, input logic m,
                         input logic ci, input logic [1:0] iv,
                         input logic [7:0] a, input logic [7:0] b);
        in_valid = v;
        in_cmd   = c;
        in_mode  = m;
        in_cin   = ci;
        in_iv    = iv;
        in_opa   = a;
        in_opb   = b;
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        in_iv    = 2'b00;
    endtask

    // Advance across one rising edge and land mid-cycle for sampling.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        txn_t got;
        n_checks++;
        if (ce !== 1'b0) begin n_fail++; $display("FAIL reset_ce: got %b expected 0", ce); end
        n_checks++;
        if (terr !== 1'b0) begin n_fail++; $display("FAIL reset_terr: got %b expected 0", terr); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
        got = observed();
        n_checks++;
        if (got !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", got); end
    endtask

    task automatic test_complete();
        txn_t got, e;
        drive(1'b1, 4'd0, 1'b1, 1'b0, 2'b11, 8'd255, 8'd255);
        exp_q.push_back('{a: 8'd255, b: 8'd255, cmd: 4'd0, mode: 1'b1, cin: 1'b0, iv: 2'b11});
        tick();
        idle_in();
        n_checks++;
        if (ce !== 1'b1) begin n_fail++; $display("FAIL complete_ce: got %b expected 1", ce); end
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL complete_ready_low: got %b expected 0", in_ready); end
        got = observed();
        e   = exp_q.pop_front();
        n_checks++;
        if (got !== e) begin n_fail++; $display("FAIL complete_fields: got %h expected %h", got, e); end
        tick();
        n_checks++;
        if (ce !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL complete_after: got ce=%b ready=%b expected ce=0 ready=1", ce, in_ready);
        end
        got = observed();
        n_checks++;
        if (got !== e) begin n_fail++; $display("FAIL complete_hold: got %h expected %h", got, e); end
    endtask

    task automatic test_split();
        txn_t got, e;
        drive(1'b1, 4'd1, 1'b1, 1'b1, 2'b01, 8'd40, 8'd77);
        exp_q.push_back('{a: 8'd40, b: 8'd20, cmd: 4'd1, mode: 1'b1, cin: 1'b1, iv: 2'b11});
        tick();
        idle_in();
        n_checks++;
        if (ce !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL split_wait: got ce=%b ready=%b expected ce=0 ready=1", ce, in_ready);
        end
        tick();
        drive(1'b1, 4'd3, 1'b0, 1'b0, 2'b01, 8'd99, 8'd0);
        tick();
        n_checks++;
        if (ce !== 1'b0) begin n_fail++; $display("FAIL split_dup_a: got ce=%b expected 0", ce); end
        drive(1'b1, 4'd3, 1'b0, 1'b0, 2'b10, 8'd0, 8'd20);
        tick();
        idle_in();
        n_checks++;
        if (ce !== 1'b1) begin n_fail++; $display("FAIL split_ce: got %b expected 1", ce); end
        got = observed();
        e   = exp_q.pop_front();
        n_checks++;
        if (got !== e) begin n_fail++; $display("FAIL split_fields: got %h expected %h", got, e); end
        tick();
    endtask

    task automatic test_single();
        txn_t got, e;
        drive(1'b1, 4'd4, 1'b1, 1'b0, 2'b01, 8'd55, 8'd66);
        exp_q.push_back('{a: 8'd55, b: 8'd0, cmd: 4'd4, mode: 1'b1, cin: 1'b0, iv: 2'b01});
        tick();
        idle_in();
        n_checks++;
        if (ce !== 1'b1) begin n_fail++; $display("FAIL single_a_ce: got %b expected 1", ce); end
        got = observed();
        e   = exp_q.pop_front();
        n_checks++;
        if (got !== e) begin n_fail++; $display("FAIL single_a_fields: got %h expected %h", got, e); end
        tick();
        drive(1'b1, 4'd7, 1'b0, 1'b1, 2'b01, 8'd12, 8'd0);
        exp_q.push_back('{a: 8'd0, b: 8'hCC, cmd: 4'd7, mode: 1'b0, cin: 1'b1, iv: 2'b10});
        tick();
        idle_in();
        n_checks++;
        if (ce !== 1'b0) begin n_fail++; $display("FAIL single_b_wait: got ce=%b expected 0", ce); end
        drive(1'b1, 4'd0, 1'b1, 1'b0, 2'b10, 8'd0, 8'hCC);
        tick();
        idle_in();
        n_checks++;
        if (ce !== 1'b1) begin n_fail++; $display("FAIL single_b_ce: got %b expected 1", ce); end
        got = observed();
        e   = exp_q.pop_front();
        n_checks++;
        if (got !== e) begin n_fail++; $display("FAIL single_b_fields: got %h expected %h", got, e); end
        tick();
    endtask

    task automatic test_timeout();
        txn_t got, e;
        drive(1'b1, 4'd0, 1'b1, 1'b0, 2'b01, 8'd3, 8'd0);
        tick();
        idle_in();
        for (int j = 1; j <= TIMEOUT; j++) begin
            tick();
            n_checks++;
            if (terr !== (j == TIMEOUT) || ce !== 1'b0 || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL timeout_cycle%0d: got err=%b ce=%b ready=%b expected err=%b ce=0 ready=1",
                         j, terr, ce, in_ready, (j == TIMEOUT));
            end
        end
        drive(1'b1, 4'd2, 1'b1, 1'b0, 2'b11, 8'd8, 8'd9);
        exp_q.push_back('{a: 8'd8, b: 8'd9, cmd: 4'd2, mode: 1'b1, cin: 1'b0, iv: 2'b11});
        tick();
        idle_in();
        n_checks++;
        if (ce !== 1'b1 || terr !== 1'b0) begin
            n_fail++; $display("FAIL timeout_next: got ce=%b err=%b expected ce=1 err=0", ce, terr);
        end
        got = observed();
        e   = exp_q.pop_front();
        n_checks++;
        if (got !== e) begin n_fail++; $display("FAIL timeout_next_fields: got %h expected %h", got, e); end
        tick();
        // Operand arriving on the last allowed WAIT cycle still completes.
        drive(1'b1, 4'd0, 1'b1, 1'b0, 2'b01, 8'd1, 8'd0);
        exp_q.push_back('{a: 8'd1, b: 8'd2, cmd: 4'd0, mode: 1'b1, cin: 1'b0, iv: 2'b11});
        tick();
        idle_in();
        for (int j = 1; j < TIMEOUT; j++) begin
            tick();
            n_checks++;
            if (terr !== 1'b0 || ce !== 1'b0) begin
                n_fail++; $display("FAIL late_wait%0d: got err=%b ce=%b expected 0 0", j, terr, ce);
            end
        end
        drive(1'b1, 4'd0, 1'b1, 1'b0, 2'b10, 8'd0, 8'd2);
        tick();
        idle_in();
        n_checks++;
        if (ce !== 1'b1 || terr !== 1'b0) begin
            n_fail++; $display("FAIL late_complete: got ce=%b err=%b expected ce=1 err=0", ce, terr);
        end
        got = observed();
        e   = exp_q.pop_front();
        n_checks++;
        if (got !== e) begin n_fail++; $display("FAIL late_fields: got %h expected %h", got, e); end
        tick();
    endtask

    task automatic test_mul_gap();
        txn_t got, e;
        drive(1'b1, 4'd9, 1'b1, 1'b0, 2'b11, 8'd7, 8'd5);
        exp_q.push_back('{a: 8'd7, b: 8'd5, cmd: 4'd9, mode: 1'b1, cin: 1'b0, iv: 2'b11});
        tick();
        n_checks++;
        if (ce !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL mul_issue: got ce=%b ready=%b expected ce=1 ready=0", ce, in_ready);
        end
        got = observed();
        e   = exp_q.pop_front();
        n_checks++;
        if (got !== e) begin n_fail++; $display("FAIL mul_fields: got %h expected %h", got, e); end
        // Next request is held valid through ISSUE and the whole gap.
        drive(1'b1, 4'd2, 1'b1, 1'b1, 2'b11, 8'd10, 8'd3);
        exp_q.push_back('{a: 8'd10, b: 8'd3, cmd: 4'd2, mode: 1'b1, cin: 1'b1, iv: 2'b11});
        for (int j = 1; j <= MUL_GAP; j++) begin
            tick();
            n_checks++;
            if (ce !== 1'b0 || in_ready !== 1'b0) begin
                n_fail++; $display("FAIL mul_gap%0d: got ce=%b ready=%b expected ce=0 ready=0", j, ce, in_ready);
            end
        end
        tick();
        n_checks++;
        if (ce !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL mul_idle: got ce=%b ready=%b expected ce=0 ready=1", ce, in_ready);
        end
        tick();
        idle_in();
        n_checks++;
        if (ce !== 1'b1) begin n_fail++; $display("FAIL mul_next_ce: got %b expected 1", ce); end
        got = observed();
        e   = exp_q.pop_front();
        n_checks++;
        if (got !== e) begin n_fail++; $display("FAIL mul_next_fields: got %h expected %h", got, e); end
        tick();
    endtask

    task automatic test_back_to_back();
        txn_t got, e;
        drive(1'b1, 4'd5, 1'b0, 1'b0, 2'b00, 8'd1, 8'd1);
        tick();
        n_checks++;
        if (ce !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL empty_mask: got ce=%b ready=%b expected ce=0 ready=1", ce, in_ready);
        end
        drive(1'b1, 4'd1, 1'b0, 1'b0, 2'b11, 8'hF0, 8'h3C);
        exp_q.push_back('{a: 8'hF0, b: 8'h3C, cmd: 4'd1, mode: 1'b0, cin: 1'b0, iv: 2'b11});
        tick();
        drive(1'b1, 4'd2, 1'b0, 1'b0, 2'b11, 8'hAA, 8'h55);
        exp_q.push_back('{a: 8'hAA, b: 8'h55, cmd: 4'd2, mode: 1'b0, cin: 1'b0, iv: 2'b11});
        got = observed();
        e   = exp_q.pop_front();
        n_checks++;
        if (ce !== 1'b1 || got !== e) begin
            n_fail++; $display("FAIL b2b_first: got ce=%b %h expected ce=1 %h", ce, got, e);
        end
        tick();
        n_checks++;
        if (ce !== 1'b0) begin n_fail++; $display("FAIL b2b_gap: got ce=%b expected 0", ce); end
        tick();
        idle_in();
        got = observed();
        e   = exp_q.pop_front();
        n_checks++;
        if (ce !== 1'b1 || got !== e) begin
            n_fail++; $display("FAIL b2b_second: got ce=%b %h expected ce=1 %h", ce, got, e);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        txn_t got;
        drive(1'b1, 4'd0, 1'b1, 1'b0, 2'b01, 8'd9, 8'd0);
        tick();
        idle_in();
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        got = observed();
        n_checks++;
        if (got !== '0 || ce !== 1'b0 || terr !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_async: got out=%h ce=%b err=%b ready=%b expected 0 0 0 1",
                     got, ce, terr, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int j = 1; j <= TIMEOUT + 2; j++) begin
            tick();
            n_checks++;
            if (ce !== 1'b0 || terr !== 1'b0) begin
                n_fail++; $display("FAIL reset_stale%0d: got ce=%b err=%b expected 0 0", j, ce, terr);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 4'd0, 1'b0, 1'b0, 2'b00, 8'd0, 8'd0);
        #2;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        test_complete();
        test_split();
        test_single();
        test_timeout();
        test_mul_gap();
        test_back_to_back();
        test_reset_mid();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
